// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous word memory between the instruction
//   fetch (IF) requester and the data-memory (DM) load/store requester.
//   DM has priority. IF is guaranteed a grant after MAX_DM_STREAK consecutive
//   DM grants made while IF was waiting.
//
//   Each access runs IDLE (arbitrate) -> ACCESS (MEM_LATENCY cycles) ->
//   RESP (1 cycle). The rvalid pulse and read data appear in the cycle after
//   RESP, so req-to-rvalid is MEM_LATENCY + 2 cycles.
//
// Ports
//   clk_i/rst_n : clock, asynchronous active-low reset (port names clk, rst_n)
//   if_*        : fetch request/grant/response
//   dm_*        : load/store request/grant/response
//   mem_*       : memory strobe, write enable, byte enables, word address,
//                 write data and read data
//   busy        : high whenever the sequencer is not IDLE
//   perf_*      : grant/conflict counters
//
// Configuration
//   MEM_ARB_PERF_EN : when defined, perf_* are saturating event counters;
//                     otherwise the perf_* ports are tied to 0.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned MAX_DM_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_dm_cnt,
  output logic [31:0]       perf_conf_cnt
);

  localparam int unsigned SW = (MAX_DM_STREAK < 2) ? 1 : $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              op_we_q, op_we_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              pick_if;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_we_d     = op_we_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    pick_if     = if_req && (!dm_req || (streak_q == SW'(MAX_DM_STREAK)));

    unique case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          state_d  = S_ACCESS;
          cnt_d    = 3'(MEM_LATENCY);
          mem_en_d = 1'b1;
          if (pick_if) begin
            owner_d    = OWN_IF;
            op_we_d    = 1'b0;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'hF;
            mem_addr_d = if_addr[ADDR_W+1:2];
            if_gnt_d   = 1'b1;
            streak_d   = '0;
          end else begin
            owner_d     = OWN_DM;
            op_we_d     = dm_we;
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr[ADDR_W+1:2];
            mem_wdata_d = dm_wdata;
            dm_gnt_d    = 1'b1;
            if (!if_req)
              streak_d = '0;
            else if (streak_q != SW'(MAX_DM_STREAK))
              streak_d = streak_q + 1'b1;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 3'd1) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (owner_q == OWN_IF) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else begin
          dm_rvalid_d = 1'b1;
          // Stores only acknowledge; dm_rdata keeps the last loaded word.
          if (!op_we_q) dm_rdata_d = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      op_we_q     <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_we_q     <= op_we_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_dm_q, perf_conf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q   <= '0;
      perf_dm_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (if_gnt_q && (perf_if_q != '1)) perf_if_q <= perf_if_q + 32'd1;
      if (dm_gnt_q && (perf_dm_q != '1)) perf_dm_q <= perf_dm_q + 32'd1;
      if ((state_q == S_IDLE) && if_req && dm_req && (perf_conf_q != '1))
        perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_if_cnt   = perf_if_q;
  assign perf_dm_cnt   = perf_dm_q;
  assign perf_conf_cnt = perf_conf_q;
`else
  assign perf_if_cnt   = '0;
  assign perf_dm_cnt   = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 for
// reset, fetch, store, abort and conflict sequences; a second instance at
// MEM_LATENCY=4 for the long-latency load.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, perf_if_cnt, perf_dm_cnt, perf_conf_cnt;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  logic        d4_req;
  logic [31:0] d4_addr, d4_mem_rdata;
  logic        d4_if_gnt, d4_if_rvalid, d4_dm_gnt, d4_dm_rvalid, d4_mem_en, d4_mem_we, d4_busy;
  logic [31:0] d4_if_rdata, d4_dm_rdata, d4_mem_wdata, d4_pif, d4_pdm, d4_pconf;
  logic [3:0]  d4_mem_be;
  logic [9:0]  d4_mem_addr;

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .MEM_LATENCY(1), .MAX_DM_STREAK(3)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_conf_cnt(perf_conf_cnt)
  );

  mem_port_arbiter #(.ADDR_W(10), .MEM_LATENCY(4), .MAX_DM_STREAK(3)) u_l4 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'h0), .if_gnt(d4_if_gnt), .if_rvalid(d4_if_rvalid), .if_rdata(d4_if_rdata),
    .dm_req(d4_req), .dm_we(1'b0), .dm_be(4'h0), .dm_addr(d4_addr), .dm_wdata(32'h0),
    .dm_gnt(d4_dm_gnt), .dm_rvalid(d4_dm_rvalid), .dm_rdata(d4_dm_rdata),
    .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_be(d4_mem_be), .mem_addr(d4_mem_addr),
    .mem_wdata(d4_mem_wdata), .mem_rdata(d4_mem_rdata), .busy(d4_busy),
    .perf_if_cnt(d4_pif), .perf_dm_cnt(d4_pdm), .perf_conf_cnt(d4_pconf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] order;
    int unsigned g, last_k, rv_k, busy_n;
    logic seen_rv;

    order = 8'b1110_1110; // 1 = DM grant, 0 = IF grant; MSB first
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = 32'hDEADBEEF;
    d4_req = 1'b0; d4_addr = '0; d4_mem_rdata = 32'hCAFEF00D;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {24'h0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy, d4_busy}, 32'h0);
    chk("rst_mem", {18'h0, mem_be, mem_addr}, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'h0);
    chk("rst_perf", perf_if_cnt | perf_dm_cnt | perf_conf_cnt, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // IF fetch: cycle T
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk); // T+1
    chk("if_gnt", {30'h0, if_gnt, dm_gnt}, 32'h2);
    chk("if_mem", {16'h0, mem_en, mem_we, mem_be, mem_addr}, {16'h0, 1'b1, 1'b0, 4'hF, 10'd4});
    chk("if_busy", {31'h0, busy}, 32'h1);
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    @(negedge clk); // T+2
    chk("if_access_drop", {16'h0, mem_en, mem_we, mem_be, mem_addr, if_rvalid, if_gnt}, {16'h0, 16'h4 << 2});
    @(negedge clk); // T+3
    chk("if_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    chk("if_done_busy", {31'h0, busy}, 32'h0);

    // DM store
    mem_rdata = 32'h5555_AAAA;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'h1234;
    @(negedge clk); // T+1
    chk("st_gnt", {30'h0, if_gnt, dm_gnt}, 32'h1);
    chk("st_mem", {16'h0, mem_en, mem_we, mem_be, mem_addr}, {16'h0, 1'b1, 1'b1, 4'b0011, 10'd8});
    chk("st_wdata", mem_wdata, 32'h1234);
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
    @(negedge clk); // T+2
    chk("st_dm_rvalid_early", {31'h0, dm_rvalid}, 32'h0);
    @(negedge clk); // T+3
    chk("st_dm_rvalid", {31'h0, dm_rvalid}, 32'h1);
    chk("st_dm_rdata_held", dm_rdata, 32'h0);
    @(negedge clk);
    chk("st_rvalid_pulse", {31'h0, dm_rvalid}, 32'h0);

    // Reset asserted mid-ACCESS
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk); // T+1: ACCESS
    chk("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_outs", {28'h0, mem_en, if_gnt, if_rvalid, |if_rdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen_rv = seen_rv | if_rvalid | dm_rvalid;
    end
    chk("abort_no_rvalid", {31'h0, seen_rv}, 32'h0);

    // Conflict: both requests held for 8 grants
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_be = 4'hF;
    g = 0; last_k = 0;
    for (int k = 1; k <= 40 && g < 8; k++) begin
      @(negedge clk);
      if (if_gnt || dm_gnt) begin
        chk($sformatf("conf_order%0d", g), {30'h0, if_gnt, dm_gnt}, {30'h0, !order[7-g], order[7-g]});
        if (g > 0) chk($sformatf("conf_space%0d", g), k - last_k, 32'd3);
        last_k = k;
        g++;
        if (g == 8) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
    end
    chk("conf_grants", g, 32'd8);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    chk("perf_dm", perf_dm_cnt, 32'd6);
    chk("perf_if", perf_if_cnt, 32'd2);
    chk("perf_conf", perf_conf_cnt, 32'd8);
`else
    chk("perf_dm", perf_dm_cnt, 32'd0);
    chk("perf_if", perf_if_cnt, 32'd0);
    chk("perf_conf", perf_conf_cnt, 32'd0);
`endif

    // MEM_LATENCY=4 load on the second instance
    d4_req = 1'b1; d4_addr = 32'h3C;
    rv_k = 0; busy_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (d4_dm_gnt) begin
        chk("l4_gnt_cycle", k, 32'd1);
        chk("l4_mem_addr", {22'h0, d4_mem_addr}, 32'd15);
        d4_req = 1'b0;
      end
      if (d4_busy) busy_n++;
      if (d4_dm_rvalid && rv_k == 0) begin
        rv_k = k;
        chk("l4_rdata", d4_dm_rdata, 32'hCAFEF00D);
      end
    end
    chk("l4_rvalid_cycle", rv_k, 32'd6);
    chk("l4_busy_cycles", busy_n, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
